// File: rtl/div32.sv
// div32 -- sequential unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk    : single clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   start  : begin a division; accepted only when not busy
//   x      : unsigned dividend, captured on the accepting edge
//   y      : unsigned divisor, captured on the accepting edge
//   busy   : high while a division is iterating (RUN)
//   done   : one-cycle pulse; q, r and dz are valid during it
//   q      : unsigned quotient (all ones on divide-by-zero)
//   r      : unsigned remainder (dividend on divide-by-zero)
//   dz     : divide-by-zero flag of the last completed operation
//
// A non-zero divisor takes W RUN cycles. A zero divisor is resolved
// directly on the accepting edge. q, r and dz only change on completion
// (dz is also cleared on acceptance), so they stay stable through RUN.
module div32 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         dz
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [W-1:0]    rem_r, rem_s;     // partial remainder
  logic [W-1:0]    dvd_r, dvd_s;     // dividend shifting out, quotient shifting in
  logic [W-1:0]    dvs_r, dvs_s;     // latched divisor
  logic [W-1:0]    q_r, q_s;
  logic [W-1:0]    r_r, r_s;
  logic            dz_r, dz_s;
  logic            busy_r, done_r;

  logic [W:0]      shifted_s;
  logic [W:0]      trial_s;
  logic            qbit_s;
  logic [W-1:0]    step_rem_s;
  logic [W-1:0]    step_dvd_s;

  // One restoring step plus next-state and next-datapath selection.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rem_s   = rem_r;
    dvd_s   = dvd_r;
    dvs_s   = dvs_r;
    q_s     = q_r;
    r_s     = r_r;
    dz_s    = dz_r;

    // Since rem < divisor always holds, the W+1 bit difference is
    // non-negative exactly when its top bit is clear.
    shifted_s = {rem_r, dvd_r[W-1]};
    trial_s   = shifted_s - {1'b0, dvs_r};
    if (trial_s[W] == 1'b0) begin
      step_rem_s = trial_s[W-1:0];
      qbit_s     = 1'b1;
    end else begin
      step_rem_s = shifted_s[W-1:0];
      qbit_s     = 1'b0;
    end
    step_dvd_s = {dvd_r[W-2:0], qbit_s};

    case (state_r)
      IDLE, DONE: begin
        if (start == 1'b1) begin
          dvd_s = x;
          dvs_s = y;
          rem_s = '0;
          cnt_s = CW'(W);
          dz_s  = 1'b0;
          if (y == '0) begin
            state_s = DONE;
            q_s     = '1;
            r_s     = x;
            dz_s    = 1'b1;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // start is deliberately ignored here
        rem_s = step_rem_s;
        dvd_s = step_dvd_s;
        cnt_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          state_s = DONE;
          q_s     = step_dvd_s;
          r_s     = step_rem_s;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      rem_r   <= '0;
      dvd_r   <= '0;
      dvs_r   <= '0;
      q_r     <= '0;
      r_r     <= '0;
      dz_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      rem_r   <= rem_s;
      dvd_r   <= dvd_s;
      dvs_r   <= dvs_s;
      q_r     <= q_s;
      r_r     <= r_s;
      dz_r    <= dz_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign q    = q_r;
  assign r    = r_r;
  assign dz   = dz_r;

endmodule

// File: tb/tb_div32.sv
// tb_div32 -- self-checking bench for div32 (W=32).
// Expected results come from a behavioural model (/ and %) and are queued
// when an operation is launched; a monitor pops them on every done pulse.
module tb_div32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        dz;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  div32 #(.W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (b == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("q", {32'd0, q}, {32'd0, e.q});
        check_eq("r", {32'd0, r}, {32'd0, e.r});
        check_eq("dz", {63'd0, dz}, {63'd0, e.dz});
      end
    end
  end

  // Launch one division from a negedge and return at the negedge where done
  // is seen. hold keeps start high (back-to-back chaining); poke >= 0 pulses
  // a competing start that many cycles into RUN.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input int poke);
    int          lat;
    int          busy_n;
    int          q_moves;
    logic [31:0] q0;
    logic [31:0] r0;
    x     = a;
    y     = b;
    start = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    if (!hold) begin
      start = 1'b0;
      x     = $urandom;
      y     = $urandom;
    end
    lat     = 0;
    busy_n  = 0;
    q_moves = 0;
    q0      = q;
    r0      = r;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_n++;
      if (q !== q0 || r !== r0) q_moves++;
      if (poke >= 0 && lat == poke) begin
        start = 1'b1;
        x     = 32'd9;
        y     = 32'd3;
      end
      if (poke >= 0 && lat == poke + 1) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 64'(lat), (b == 32'd0) ? 64'd0 : 64'd32);
    check_eq("busy_cycles", 64'(busy_n), (b == 32'd0) ? 64'd0 : 64'd32);
    check_eq("hold_in_run", 64'(q_moves), 64'd0);
    if (!hold) begin
      @(negedge clk);
      check_eq("done_one_cycle", {63'd0, done}, 64'd0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b0;
    start = 1'b0;
    x     = 32'd0;
    y     = 32'd0;
    #2;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_q", {32'd0, q}, 64'd0);
    check_eq("rst_r", {32'd0, r}, 64'd0);
    check_eq("rst_dz", {63'd0, dz}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic and corner operands
    run_op(32'd100, 32'd7, 1'b0, -1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1);
    run_op(32'd3, 32'd10, 1'b0, -1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, -1);
    run_op(32'd0, 32'd13, 1'b0, -1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
    run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, -1);

    // divide by zero, then a valid division clears dz
    run_op(32'd5, 32'd0, 1'b0, -1);
    run_op(32'd50, 32'd5, 1'b0, -1);

    // competing start mid-run is ignored
    run_op(32'd100, 32'd7, 1'b0, 10);

    // start held through DONE: back-to-back, including a zero divisor
    run_op(32'd1234567, 32'd89, 1'b1, -1);
    run_op(32'd77, 32'd0, 1'b1, -1);
    run_op(32'hDEAD_BEEF, 32'd3, 1'b1, -1);
    run_op(32'd42, 32'd42, 1'b0, -1);

    // random operands with divisors of varying magnitude
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op(ra, rb, 1'b0, -1);
    end

    // reset in the middle of RUN aborts with no done pulse
    run_op(32'd100, 32'd7, 1'b0, -1);
    x     = 32'd100;
    y     = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_done", {63'd0, done}, 64'd0);
    check_eq("abort_q", {32'd0, q}, 64'd0);
    check_eq("abort_r", {32'd0, r}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run_op(32'd1000, 32'd33, 1'b0, -1);

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
